// File: rtl/axis_mirror_arbiter.sv
// Packet-level round-robin merge of the read/write mirror streams onto one tagged AXI4-Stream output.
// Latency: 1 cycle per beat; 1 cycle grant from IDLE; one IDLE cycle between packets.
// Backpressure: m_tready stalls only the granted input; over-long tails are drained regardless of m_tready.
module axis_mirror_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic                  s0_tlast,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  input  logic                  s1_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tdest,
  input  logic                  forward_en,
  input  logic                  err_clear,
  output logic [CNT_WIDTH-1:0]  pkt_count0,
  output logic [CNT_WIDTH-1:0]  pkt_count1,
  output logic [1:0]            err_overlong,
  output logic [1:0]            DBG_state,
  output logic                  DBG_grant
);

  localparam int BCW = $clog2(MAX_BEATS);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state;
  logic                  grant;
  logic                  last_grant;
  logic [BCW-1:0]        beat_cnt;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  sel_vld;
  logic                  sel_last;
  logic                  in_rdy;
  logic                  pass_acc;
  logic                  at_limit;
  logic                  pkt_done;
  logic [1:0]            err_set;

  assign sel_dat  = grant ? s1_tdata  : s0_tdata;
  assign sel_vld  = grant ? s1_tvalid : s0_tvalid;
  assign sel_last = grant ? s1_tlast  : s0_tlast;

  // DRAIN swallows the tail without touching the output, so it ignores m_tready.
  assign in_rdy    = ((state == ST_PASS) && (!m_tvalid || m_tready)) || (state == ST_DRAIN);
  assign s0_tready = in_rdy && !grant;
  assign s1_tready = in_rdy && grant;

  assign at_limit = (beat_cnt == BCW'(MAX_BEATS - 1));
  assign pass_acc = (state == ST_PASS) && sel_vld && in_rdy;
  assign pkt_done = pass_acc && (sel_last || at_limit);
  assign err_set  = (pass_acc && at_limit && !sel_last) ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign DBG_state = state;
  assign DBG_grant = grant;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (forward_en && (s0_tvalid || s1_tvalid)) begin
            state    <= ST_PASS;
            beat_cnt <= '0;
            grant    <= (s0_tvalid && s1_tvalid) ? !last_grant : s1_tvalid;
          end
        end
        ST_PASS: begin
          if (pass_acc) begin
            if (sel_last || at_limit) begin
              last_grant <= grant;
              beat_cnt   <= '0;
              state      <= sel_last ? ST_IDLE : ST_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (sel_vld && sel_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single output stage: reload on accept, otherwise empty when the sink takes the beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tdest  <= 1'b0;
    end else if (pass_acc) begin
      m_tvalid <= 1'b1;
      m_tdata  <= sel_dat;
      m_tlast  <= sel_last || at_limit;
      m_tdest  <= grant;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_count0   <= '0;
      pkt_count1   <= '0;
      err_overlong <= 2'b00;
    end else begin
      if (pkt_done && !grant) pkt_count0 <= pkt_count0 + 1'b1;
      if (pkt_done && grant)  pkt_count1 <= pkt_count1 + 1'b1;
      err_overlong <= (err_overlong & ~{2{err_clear}}) | err_set;
    end
  end

endmodule

// File: tb/tb_axis_mirror_arbiter.sv
// Directed bench: instance a (MAX_BEATS=16) for normal traffic, instance b (MAX_BEATS=4) for the over-long case.
module tb_axis_mirror_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] s0_tdata = '0, s1_tdata = '0;
  logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic        s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic        m_tready = 1'b1;
  logic        forward_en = 1'b1;
  logic        err_clear = 1'b0;
  logic        sel_ol = 1'b0;

  logic [63:0] a_m_tdata, b_m_tdata;
  logic        a_m_tvalid, b_m_tvalid, a_m_tlast, b_m_tlast, a_m_tdest, b_m_tdest;
  logic        a_s0_tready, b_s0_tready, a_s1_tready, b_s1_tready;
  logic [15:0] a_cnt0, b_cnt0, a_cnt1, b_cnt1;
  logic [1:0]  a_err, b_err, a_state, b_state;
  logic        a_grant, b_grant;

  always #5 aclk = ~aclk;

  axis_mirror_arbiter #(.DATA_WIDTH(64), .MAX_BEATS(16), .CNT_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid && !sel_ol), .s0_tready(a_s0_tready), .s0_tlast(s0_tlast),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid && !sel_ol), .s1_tready(a_s1_tready), .s1_tlast(s1_tlast),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(m_tready), .m_tlast(a_m_tlast), .m_tdest(a_m_tdest),
    .forward_en(forward_en), .err_clear(err_clear),
    .pkt_count0(a_cnt0), .pkt_count1(a_cnt1), .err_overlong(a_err),
    .DBG_state(a_state), .DBG_grant(a_grant)
  );

  axis_mirror_arbiter #(.DATA_WIDTH(64), .MAX_BEATS(4), .CNT_WIDTH(16)) dut_ol (
    .aclk(aclk), .aresetn(aresetn),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid && sel_ol), .s0_tready(b_s0_tready), .s0_tlast(s0_tlast),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid && sel_ol), .s1_tready(b_s1_tready), .s1_tlast(s1_tlast),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(m_tready), .m_tlast(b_m_tlast), .m_tdest(b_m_tdest),
    .forward_en(forward_en), .err_clear(err_clear),
    .pkt_count0(b_cnt0), .pkt_count1(b_cnt1), .err_overlong(b_err),
    .DBG_state(b_state), .DBG_grant(b_grant)
  );

  wire [63:0] m_tdata    = sel_ol ? b_m_tdata   : a_m_tdata;
  wire        m_tvalid   = sel_ol ? b_m_tvalid  : a_m_tvalid;
  wire        m_tlast    = sel_ol ? b_m_tlast   : a_m_tlast;
  wire        m_tdest    = sel_ol ? b_m_tdest   : a_m_tdest;
  wire        s0_tready  = sel_ol ? b_s0_tready : a_s0_tready;
  wire        s1_tready  = sel_ol ? b_s1_tready : a_s1_tready;
  wire [15:0] pkt_count0 = sel_ol ? b_cnt0      : a_cnt0;
  wire [15:0] pkt_count1 = sel_ol ? b_cnt1      : a_cnt1;
  wire [1:0]  err_ovl    = sel_ol ? b_err       : a_err;
  wire [1:0]  dbg_state  = sel_ol ? b_state     : a_state;
  wire        dbg_grant  = sel_ol ? b_grant     : a_grant;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [63:0] q_dat[$];
  logic        q_last[$];
  logic        q_dest[$];
  int          q_cyc[$];
  int          stall_err = 0;
  bit          stall_prev = 0;
  logic [63:0] prev_dat;
  logic        prev_last, prev_dest;
  bit          s0_rdy_seen = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // Output beats are logged at the falling edge, where a valid&&ready pair means the beat transfers next edge.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      q_dat.push_back(m_tdata);
      q_last.push_back(m_tlast);
      q_dest.push_back(m_tdest);
      q_cyc.push_back(cyc);
    end
    if (stall_prev && (!m_tvalid || m_tdata !== prev_dat || m_tlast !== prev_last || m_tdest !== prev_dest))
      stall_err++;
    stall_prev = aresetn && m_tvalid && !m_tready;
    prev_dat   = m_tdata;
    prev_last  = m_tlast;
    prev_dest  = m_tdest;
    if (aresetn && s0_tready) s0_rdy_seen = 1;
  end

  task automatic apply_reset();
    aresetn = 1'b0;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    m_tready = 1'b1; forward_en = 1'b1; err_clear = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    q_dat.delete(); q_last.delete(); q_dest.delete(); q_cyc.delete();
    stall_err = 0; s0_rdy_seen = 0;
    @(posedge aclk);
    #1;
  endtask

  task automatic send_pkt(input bit src, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      bit got;
      int waited;
      if (src) begin s1_tvalid = 1'b1; s1_tdata = base + 64'(i); s1_tlast = (i == n - 1); end
      else     begin s0_tvalid = 1'b1; s0_tdata = base + 64'(i); s0_tlast = (i == n - 1); end
      got = 0;
      waited = 0;
      while (!got && waited < 60) begin
        @(negedge aclk);
        got = src ? s1_tready : s0_tready;
        @(posedge aclk);
        #1;
        waited++;
      end
      if (!got) begin
        total++; bad++;
        $display("FAIL send_timeout src=%0d beat=%0d: no tready after %0d cycles", src, i, waited);
        break;
      end
    end
    if (src) begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
    else     begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
  endtask

  task automatic test_reset();
    sel_ol = 1'b0;
    aresetn = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0)    begin bad++; $display("FAIL rst_m_tvalid got=%b exp=0", m_tvalid); end
    total++; if (m_tdata !== 64'd0)    begin bad++; $display("FAIL rst_m_tdata got=%h exp=0", m_tdata); end
    total++; if (m_tlast !== 1'b0)     begin bad++; $display("FAIL rst_m_tlast got=%b exp=0", m_tlast); end
    total++; if (m_tdest !== 1'b0)     begin bad++; $display("FAIL rst_m_tdest got=%b exp=0", m_tdest); end
    total++; if (s0_tready !== 1'b0 || s1_tready !== 1'b0)
      begin bad++; $display("FAIL rst_tready got=%b%b exp=00", s1_tready, s0_tready); end
    total++; if (pkt_count0 !== 16'd0 || pkt_count1 !== 16'd0)
      begin bad++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", pkt_count0, pkt_count1); end
    total++; if (err_ovl !== 2'b00)    begin bad++; $display("FAIL rst_err got=%b exp=00", err_ovl); end
    total++; if (dbg_state !== 2'd0)   begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    total++; if (dbg_grant !== 1'b0)   begin bad++; $display("FAIL rst_grant got=%b exp=0", dbg_grant); end
    apply_reset();
  endtask

  task automatic test_single();
    int t0;
    sel_ol = 1'b0;
    apply_reset();
    t0 = cyc;
    send_pkt(1'b0, 4, 64'h100);
    repeat (3) @(posedge aclk);
    #1;
    total++; if (q_dat.size() !== 4) begin bad++; $display("FAIL single_count got=%0d exp=4", q_dat.size()); end
    else begin
      total++; if (q_cyc[0] !== t0 + 2) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", q_cyc[0], t0 + 2); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q_dat[i] !== 64'h100 + 64'(i) || q_dest[i] !== 1'b0 || q_last[i] !== (i == 3)) begin
          bad++;
          $display("FAIL single_beat%0d got=%h/d%b/l%b exp=%h/d0/l%b", i, q_dat[i], q_dest[i], q_last[i], 64'h100 + 64'(i), (i == 3));
        end
      end
    end
    total++; if (pkt_count0 !== 16'd1) begin bad++; $display("FAIL single_cnt0 got=%0d exp=1", pkt_count0); end
  endtask

  task automatic test_contention();
    sel_ol = 1'b0;
    apply_reset();
    fork
      for (int k = 0; k < 3; k++) send_pkt(1'b0, 3, 64'h200 + 64'(k * 16));
      for (int k = 0; k < 3; k++) send_pkt(1'b1, 3, 64'h300 + 64'(k * 16));
    join
    repeat (3) @(posedge aclk);
    #1;
    total++; if (q_dat.size() !== 18) begin bad++; $display("FAIL cont_count got=%0d exp=18", q_dat.size()); end
    else begin
      for (int p = 0; p < 6; p++) begin
        logic [63:0] exp_base;
        exp_base = ((p % 2) ? 64'h300 : 64'h200) + 64'((p / 2) * 16);
        for (int b = 0; b < 3; b++) begin
          total++;
          if (q_dest[p*3+b] !== 1'(p % 2) || q_dat[p*3+b] !== exp_base + 64'(b) || q_last[p*3+b] !== (b == 2)) begin
            bad++;
            $display("FAIL cont_pkt%0d_beat%0d got=%h/d%b exp=%h/d%0d", p, b, q_dat[p*3+b], q_dest[p*3+b], exp_base + 64'(b), p % 2);
          end
        end
        if (p > 0) begin
          total++;
          if (q_cyc[p*3] - q_cyc[p*3-1] !== 2) begin
            bad++; $display("FAIL cont_gap%0d got=%0d exp=2", p, q_cyc[p*3] - q_cyc[p*3-1]);
          end
        end
      end
    end
    total++; if (pkt_count0 !== 16'd3 || pkt_count1 !== 16'd3)
      begin bad++; $display("FAIL cont_counts got=%0d/%0d exp=3/3", pkt_count0, pkt_count1); end
  endtask

  task automatic test_backpressure();
    bit done;
    sel_ol = 1'b0;
    apply_reset();
    done = 0;
    fork
      begin send_pkt(1'b1, 8, 64'h400); done = 1; end
      begin
        int n;
        n = 0;
        while (!done && n < 200) begin @(posedge aclk); #1; m_tready = ~m_tready; n++; end
      end
    join
    m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    total++; if (q_dat.size() !== 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", q_dat.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (q_dat[i] !== 64'h400 + 64'(i) || q_dest[i] !== 1'b1 || q_last[i] !== (i == 7)) begin
          bad++; $display("FAIL bp_beat%0d got=%h/d%b/l%b exp=%h/d1/l%b", i, q_dat[i], q_dest[i], q_last[i], 64'h400 + 64'(i), (i == 7));
        end
      end
    end
    total++; if (stall_err !== 0)   begin bad++; $display("FAIL bp_stable got=%0d changes exp=0", stall_err); end
    total++; if (s0_rdy_seen !== 0) begin bad++; $display("FAIL bp_s0_tready got=1 exp=0"); end
    total++; if (pkt_count1 !== 16'd1) begin bad++; $display("FAIL bp_cnt1 got=%0d exp=1", pkt_count1); end
  endtask

  task automatic test_overlong();
    sel_ol = 1'b1;
    apply_reset();
    send_pkt(1'b0, 6, 64'h500);
    repeat (3) @(posedge aclk);
    #1;
    total++; if (q_dat.size() !== 4) begin bad++; $display("FAIL ol_count got=%0d exp=4", q_dat.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q_dat[i] !== 64'h500 + 64'(i) || q_last[i] !== (i == 3)) begin
          bad++; $display("FAIL ol_beat%0d got=%h/l%b exp=%h/l%b", i, q_dat[i], q_last[i], 64'h500 + 64'(i), (i == 3));
        end
      end
    end
    total++; if (err_ovl !== 2'b01)    begin bad++; $display("FAIL ol_err got=%b exp=01", err_ovl); end
    total++; if (pkt_count0 !== 16'd1) begin bad++; $display("FAIL ol_cnt0 got=%0d exp=1", pkt_count0); end
    total++; if (dbg_state !== 2'd0)   begin bad++; $display("FAIL ol_state got=%0d exp=0", dbg_state); end
    err_clear = 1'b1;
    @(posedge aclk); #1;
    err_clear = 1'b0;
    total++; if (err_ovl !== 2'b00) begin bad++; $display("FAIL ol_clear got=%b exp=00", err_ovl); end
    // Exactly MAX_BEATS with tlast on the last beat is legal.
    send_pkt(1'b0, 4, 64'h600);
    repeat (3) @(posedge aclk);
    #1;
    total++; if (err_ovl !== 2'b00 || pkt_count0 !== 16'd2)
      begin bad++; $display("FAIL ol_exact got=err%b/cnt%0d exp=err00/cnt2", err_ovl, pkt_count0); end
    total++; if (q_dat.size() !== 8) begin bad++; $display("FAIL ol_exact_count got=%0d exp=8", q_dat.size()); end
    sel_ol = 1'b0;
  endtask

  task automatic test_enable();
    sel_ol = 1'b0;
    apply_reset();
    fork
      send_pkt(1'b1, 5, 64'h700);
      begin
        repeat (2) @(posedge aclk);
        #1;
        forward_en = 1'b0;
        s0_tvalid = 1'b1; s0_tdata = 64'h7AA; s0_tlast = 1'b1;
      end
    join
    repeat (5) @(posedge aclk);
    #1;
    total++; if (q_dat.size() !== 5) begin bad++; $display("FAIL en_count got=%0d exp=5", q_dat.size()); end
    total++; if (pkt_count1 !== 16'd1) begin bad++; $display("FAIL en_cnt1 got=%0d exp=1", pkt_count1); end
    total++; if (s0_rdy_seen !== 0 || dbg_state !== 2'd0)
      begin bad++; $display("FAIL en_hold got=rdy%0d/state%0d exp=rdy0/state0", s0_rdy_seen, dbg_state); end
    forward_en = 1'b1;
    @(negedge aclk);
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL en_same_cycle got=%0d exp=0", dbg_state); end
    @(negedge aclk);
    total++; if (dbg_state !== 2'd1 || dbg_grant !== 1'b0 || s0_tready !== 1'b1)
      begin bad++; $display("FAIL en_grant got=st%0d/g%b/rdy%b exp=st1/g0/rdy1", dbg_state, dbg_grant, s0_tready); end
    @(posedge aclk); #1;
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    total++; if (pkt_count0 !== 16'd1 || q_dat.size() !== 6)
      begin bad++; $display("FAIL en_s0_pkt got=cnt%0d/beats%0d exp=cnt1/beats6", pkt_count0, q_dat.size()); end
  endtask

  task automatic test_reset_mid();
    sel_ol = 1'b0;
    apply_reset();
    send_pkt(1'b0, 2, 64'h800);
    repeat (2) @(posedge aclk);
    #1;
    total++; if (pkt_count0 !== 16'd1) begin bad++; $display("FAIL rm_precount got=%0d exp=1", pkt_count0); end
    s0_tvalid = 1'b1; s0_tdata = 64'h900; s0_tlast = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL rm_inflight got=%b exp=1", m_tvalid); end
    aresetn = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0 || m_tdata !== 64'd0 || m_tlast !== 1'b0 || m_tdest !== 1'b0)
      begin bad++; $display("FAIL rm_out got=v%b/%h/l%b/d%b exp=v0/0/l0/d0", m_tvalid, m_tdata, m_tlast, m_tdest); end
    total++; if (s0_tready !== 1'b0 || dbg_state !== 2'd0)
      begin bad++; $display("FAIL rm_fsm got=rdy%b/st%0d exp=rdy0/st0", s0_tready, dbg_state); end
    total++; if (pkt_count0 !== 16'd0 || pkt_count1 !== 16'd0 || err_ovl !== 2'b00)
      begin bad++; $display("FAIL rm_counts got=%0d/%0d/%b exp=0/0/00", pkt_count0, pkt_count1, err_ovl); end
    s0_tvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_overlong();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
